// File: rtl/rv32i_types.sv
// Shared widths and enums for the L2 arbiter slice.
package rv32i_types;

    localparam int S_LINE = 256;
    localparam int S_ADDR = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } l2_arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } l2_arb_port_t;

endpackage

// File: rtl/l2_rr_pick.sv
// Two-way round-robin select between the I-cache and D-cache requests.
module l2_rr_pick
    import rv32i_types::*;
(
    input  logic         i_req,
    input  logic         d_req,
    input  l2_arb_port_t last_grant,
    output l2_arb_port_t gnt,
    output logic         valid
);

    // A lone requester wins outright; on a tie the one not served last wins.
    always_comb begin
        valid = i_req | d_req;
        gnt   = ARB_I;
        if (i_req && d_req) begin
            gnt = (last_grant == ARB_I) ? ARB_D : ARB_I;
        end else if (d_req) begin
            gnt = ARB_D;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single line-wide L2 port between the L1 I-cache and D-cache.
module l2_arbiter
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [S_ADDR-1:0] i_address,
    output logic [S_LINE-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [S_ADDR-1:0] d_address,
    input  logic [S_LINE-1:0] d_wdata,
    output logic [S_LINE-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [S_ADDR-1:0] mem_address,
    output logic [S_LINE-1:0] mem_wdata,
    input  logic [S_LINE-1:0] mem_rdata,
    input  logic              mem_resp
);

    l2_arb_state_t     state_q, state_d;
    l2_arb_port_t      gnt_q, gnt_d;
    l2_arb_port_t      last_grant_q, last_grant_d;
    l2_arb_port_t      pick_gnt;
    logic              pick_valid;
    logic              lat_read_q, lat_read_d;
    logic              lat_write_q, lat_write_d;
    logic [S_ADDR-1:0] lat_addr_q, lat_addr_d;
    logic [S_LINE-1:0] lat_wdata_q, lat_wdata_d;
    logic              busy;

    l2_rr_pick u_pick (
        .i_req      (i_read),
        .d_req      (d_read | d_write),
        .last_grant (last_grant_q),
        .gnt        (pick_gnt),
        .valid      (pick_valid)
    );

    // Next-state and latch capture; live L1 inputs are only sampled in IDLE.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path infers a latch.
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        lat_read_d   = lat_read_q;
        lat_write_d  = lat_write_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d        = pick_gnt;
                    last_grant_d = pick_gnt;
                    state_d      = BUSY;
                    if (pick_gnt == ARB_I) begin
                        lat_read_d  = 1'b1;
                        lat_write_d = 1'b0;
                        lat_addr_d  = i_address;
                        lat_wdata_d = '0;
                    end else begin
                        // A writeback wins over a simultaneous read.
                        lat_read_d  = d_read & ~d_write;
                        lat_write_d = d_write;
                        lat_addr_d  = d_address;
                        lat_wdata_d = d_wdata;
                    end
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // One dead cycle lets the served L1 drop its level request.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; the latches clear so reset drives zeros out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= ARB_I;
            last_grant_q <= ARB_D;
            lat_read_q   <= 1'b0;
            lat_write_q  <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            lat_read_q   <= lat_read_d;
            lat_write_q  <= lat_write_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            assert (state_q == BUSY || !mem_resp)
                else $warning("l2_arbiter: mem_resp outside BUSY ignored");
            assert (!(state_q == IDLE && pick_valid && pick_gnt == ARB_D && d_read && d_write))
                else $warning("l2_arbiter: d_read and d_write both set, write taken");
        end
    end

    // Downstream request comes only from the latches, and only while BUSY.
    always_comb begin
        busy        = (state_q == BUSY);
        mem_read    = busy & lat_read_q;
        mem_write   = busy & lat_write_q;
        mem_address = busy ? lat_addr_q : '0;
        mem_wdata   = busy ? lat_wdata_q : '0;
        i_resp      = busy & mem_resp & (gnt_q == ARB_I);
        d_resp      = busy & mem_resp & (gnt_q == ARB_D);
        i_rdata     = mem_rdata;
        d_rdata     = mem_rdata;
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter with a queue of expected downstream transactions.
module tb_l2_arbiter;
    import rv32i_types::*;

    typedef struct {
        logic         is_d;
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } exp_t;

    logic         clk, rst_n;
    logic         i_read, i_resp;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         d_read, d_write, d_resp;
    logic [31:0]  d_address;
    logic [255:0] d_wdata, d_rdata;
    logic         mem_read, mem_write, mem_resp;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata, mem_rdata;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    l2_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [255:0] wdata);
        exp_t e;
        e.is_d  = is_d;
        e.rd    = rd;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        q.push_back(e);
    endtask

    // Acts as the L2: waits for a request, checks it, answers after lat cycles.
    task automatic serve(input int exp_wait, input int lat, input logic [255:0] rdata,
                         input logic chg, input logic [31:0] chg_addr);
        int   n;
        exp_t e;
        n = 0;
        while (!(mem_read || mem_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", n, exp_wait);
        if (q.size() == 0) begin
            check("sb_nonempty", 0, 1);
            return;
        end
        e = q.pop_front();
        check("mem_read", mem_read, e.rd);
        check("mem_write", mem_write, e.wr);
        check("mem_address", mem_address, e.addr);
        if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
        if (chg) d_address = chg_addr;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check("hold_address", mem_address, e.addr);
            check("hold_req", {mem_read, mem_write}, {e.rd, e.wr});
            check("early_resp", {i_resp, d_resp}, 2'b00);
        end
        mem_rdata = rdata;
        mem_resp  = 1'b1;
        #1;
        check("resp_addr", mem_address, e.addr);
        check("resp_pair", {i_resp, d_resp}, e.is_d ? 2'b01 : 2'b10);
        check("resp_rdata", e.is_d ? d_rdata : i_rdata, rdata);
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        check("done_resp", {i_resp, d_resp}, 2'b00);
        check("done_req", {mem_read, mem_write}, 2'b00);
        check("done_state", dut.state_q, DONE);
    endtask

    initial begin
        rst_n = 1'b0;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_wdata", mem_wdata, 256'h0);
        check("rst_resp", {i_resp, d_resp}, 2'b00);
        check("rst_state", dut.state_q, IDLE);
        rst_n = 1'b1;

        // Single I read, L2 answering two cycles after the request appears.
        i_read = 1'b1; i_address = 32'h0000_1000;
        push(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0);
        serve(1, 2, {8{32'h1234_5678}}, 1'b0, '0);
        i_read = 1'b0;
        @(negedge clk);
        check("t1_idle", dut.state_q, IDLE);

        // D writeback.
        d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = {8{32'hDEAD_BEEF}};
        push(1'b1, 1'b0, 1'b1, 32'h8000_0040, {8{32'hDEAD_BEEF}});
        serve(1, 2, {8{32'hA5A5_0F0F}}, 1'b0, '0);
        d_write = 1'b0;
        @(negedge clk);
        check("t2_idle", dut.state_q, IDLE);

        // Both request right after reset and stay held: I, D, I, D.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        i_read = 1'b1; i_address = 32'h0000_4000;
        d_read = 1'b1; d_address = 32'h0000_5000; d_wdata = {8{32'h0BAD_F00D}};
        push(1'b0, 1'b1, 1'b0, 32'h0000_4000, '0);
        push(1'b1, 1'b1, 1'b0, 32'h0000_5000, '0);
        push(1'b0, 1'b1, 1'b0, 32'h0000_4000, '0);
        push(1'b1, 1'b1, 1'b0, 32'h0000_5000, '0);
        serve(1, 1, {8{32'h1111_1111}}, 1'b0, '0);
        serve(2, 2, {8{32'h2222_2222}}, 1'b0, '0);
        serve(2, 1, {8{32'h3333_3333}}, 1'b0, '0);
        serve(2, 3, {8{32'h4444_4444}}, 1'b0, '0);
        i_read = 1'b0; d_read = 1'b0;
        @(negedge clk);
        check("t3_idle", dut.state_q, IDLE);

        // D changes its address while BUSY; the downstream address must not move.
        d_read = 1'b1; d_address = 32'h0000_0100;
        push(1'b1, 1'b1, 1'b0, 32'h0000_0100, '0);
        serve(1, 3, {8{32'h5555_AAAA}}, 1'b1, 32'h0000_0200);
        d_read = 1'b0;
        @(negedge clk);

        // Reset pulse during BUSY aborts without a response.
        i_read = 1'b1; i_address = 32'h0000_3000;
        @(negedge clk);
        check("t5_busy_read", mem_read, 1'b1);
        #2;
        rst_n = 1'b0;
        mem_resp = 1'b1;
        #1;
        check("t5_abort_req", {mem_read, mem_write}, 2'b00);
        check("t5_abort_addr", mem_address, 32'h0);
        check("t5_abort_resp", {i_resp, d_resp}, 2'b00);
        check("t5_abort_state", dut.state_q, IDLE);
        @(negedge clk);
        mem_resp = 1'b0;
        rst_n = 1'b1;
        push(1'b0, 1'b1, 1'b0, 32'h0000_3000, '0);
        serve(1, 2, {8{32'h6666_9999}}, 1'b0, '0);
        i_read = 1'b0;
        @(negedge clk);
        check("t5_idle", dut.state_q, IDLE);

        // Stray mem_resp while IDLE is ignored.
        mem_resp = 1'b1;
        #1;
        check("t6_resp", {i_resp, d_resp}, 2'b00);
        @(negedge clk);
        check("t6_state", dut.state_q, IDLE);
        mem_resp = 1'b0;
        @(negedge clk);
        check("t6_state_after", dut.state_q, IDLE);

        check("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
